data_break_unit: RTL and testbench

CPU-side responder for single-cycle data-break (DMA) requests from peripheral controllers such as the RK8E disk controller. It arbitrates the request against the CPU instruction stream and steals one memory cycle through the DB0/DB1/DB2 major states. It performs the memory read or write, returns read data to the requester, and flags requests that wait too long. It sits between the peripheral break bus and the main 32K×12 memory port, next to the CPU major-state sequencer.

---
 rtl/data_break_unit_pkg.sv | 16 +
 rtl/data_break_unit_wait_timer.sv | 53 +++++
 rtl/data_break_unit.sv | 115 +++++++++++
 tb/tb_data_break_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_break_unit_pkg.sv
// Shared types for the data-break responder: major-state codes and the
// default request wait limit.
package break_types;

  localparam int unsigned MAX_WAIT_DEFAULT = 64;

  // Codes shared with the CPU major-state sequencer so `state` can be compared
  // directly against the controller's DB1 test.
  typedef enum logic [4:0] {
    ST_IDLE = 5'd0,
    ST_DB0  = 5'd8,
    ST_DB1  = 5'd9,
    ST_DB2  = 5'd10
  } major_state_e;

endpackage

// File: rtl/data_break_unit_wait_timer.sv
// Saturating count of cycles a break request waits in IDLE without a grant;
// raises a sticky late flag when the count reaches MAX_WAIT.
module break_wait_timer
  import break_types::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic req_i,
  input  logic idle_i,
  input  logic grant_i,
  output logic late_o
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          late_q, late_d;

  always_comb begin
    cnt_d  = cnt_q;
    late_d = late_q;
    if (!req_i || grant_i) begin
      cnt_d = '0;
    end else if (idle_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Only the arrival at the limit sets the flag, so a clear while the
    // request is still stuck at saturation is not immediately undone.
    if ((cnt_q != CNT_MAX) && (cnt_d == CNT_MAX)) begin
      late_d = 1'b1;
    end
    if (clear_i) begin
      late_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      late_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      late_q <= late_d;
    end
  end

  assign late_o = late_q;

endmodule

// File: rtl/data_break_unit.sv
// CPU-side data-break responder: grants peripheral DMA requests at CPU
// major-cycle boundaries and steals one memory cycle through DB0/DB1/DB2.
module data_break_unit
  import break_types::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        data_break,
  input  logic        to_disk,
  input  logic [0:14] dmaAddr,
  input  logic [0:11] dmaDOUT,
  input  logic        cpu_boundary,
  input  logic [0:11] mem_rdata,
  output logic [0:11] dmaDIN,
  output logic        break_in_prog,
  output logic [4:0]  state,
  output logic        cpu_hold,
  output logic [0:14] mem_addr,
  output logic [0:11] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic        late,
  output logic [0:11] break_count
);

  major_state_e state_q, state_d;
  logic [0:14]  addr_q, addr_d;
  logic         rd_q, rd_d;
  logic [0:11]  wdat_q, wdat_d;
  logic [0:11]  din_q, din_d;
  logic [0:11]  count_q, count_d;
  logic         grant;

  assign grant = (state_q == ST_IDLE) && data_break && cpu_boundary;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wdat_d  = wdat_q;
    din_d   = din_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_DB0;
          addr_d  = dmaAddr;
          rd_d    = to_disk;
          wdat_d  = dmaDOUT;
        end
      end
      ST_DB0: state_d = ST_DB1;
      ST_DB1: begin
        state_d = ST_DB2;
        if (rd_q) begin
          din_d = mem_rdata;
        end
      end
      ST_DB2: begin
        state_d = ST_IDLE;
        count_d = count_q + 12'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wdat_q  <= '0;
      din_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wdat_q  <= wdat_d;
      din_q   <= din_d;
      count_q <= count_d;
    end
  end

  break_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .req_i   (data_break),
    .idle_i  (state_q == ST_IDLE),
    .grant_i (grant),
    .late_o  (late)
  );

  // Reset gates the write strobe combinationally so a break aborted in DB1
  // never reaches memory.
  assign mem_we        = (state_q == ST_DB1) && !rd_q && !reset;
  assign mem_re        = (state_q == ST_DB0) && rd_q;
  assign mem_wdata     = mem_we ? wdat_q : '0;
  assign mem_addr      = (state_q != ST_IDLE) ? addr_q : '0;
  assign break_in_prog = (state_q != ST_IDLE);
  assign cpu_hold      = (state_q != ST_IDLE);
  assign state         = state_q;
  assign dmaDIN        = din_q;
  assign break_count   = count_q;

endmodule

// File: tb/tb_data_break_unit.sv
// Scoreboard bench for data_break_unit: a requester model issues breaks and
// queues the expected transaction; a monitor checks each stolen cycle.
module tb_data_break_unit;
  import break_types::*;

  localparam int unsigned MAXW = 8;

  logic        clk = 1'b0;
  logic        reset, clear, data_break, to_disk, cpu_boundary;
  logic [0:14] dmaAddr;
  logic [0:11] dmaDOUT;
  logic [0:11] mem_rdata;
  logic [0:11] dmaDIN;
  logic        break_in_prog, cpu_hold, mem_re, mem_we, late;
  logic [4:0]  state;
  logic [0:14] mem_addr;
  logic [0:11] mem_wdata;
  logic [0:11] break_count;

  data_break_unit #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .data_break(data_break),
    .to_disk(to_disk), .dmaAddr(dmaAddr), .dmaDOUT(dmaDOUT),
    .cpu_boundary(cpu_boundary), .mem_rdata(mem_rdata), .dmaDIN(dmaDIN),
    .break_in_prog(break_in_prog), .state(state), .cpu_hold(cpu_hold),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
    .mem_we(mem_we), .late(late), .break_count(break_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [14:0] addr;
    logic        rd;
    logic [11:0] data;
    logic [11:0] din;
    logic [11:0] cnt;
  } exp_t;
  exp_t sbq[$];

  // Reference state: memory image, last word delivered, completed count, late.
  logic [11:0] ref_mem [logic [14:0]];
  logic [11:0] model_din = '0;
  logic [11:0] model_count = '0;
  logic        model_late = 1'b0;

  function automatic logic [11:0] init_word(input logic [14:0] a);
    if (a == 15'o00200) return 12'o4321;
    return a[11:0] ^ 12'o5252;
  endfunction

  function automatic logic [11:0] ref_read(input logic [14:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Main memory model: read data one cycle after mem_re.
  logic [11:0] tb_mem [0:32767];
  bit          tb_wr  [0:32767];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= tb_wr[mem_addr] ? tb_mem[mem_addr] : init_word(mem_addr);
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      tb_wr[mem_addr]  <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every grant seen must match the oldest queued expectation.
  initial begin
    exp_t t;
    forever begin
      @(negedge clk);
      if (mon_en && state == ST_DB0) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got DB0 expected no grant at %0t", $time);
        end else begin
          t = sbq.pop_front();
          check("db0_addr", 32'(mem_addr), 32'(t.addr));
          check("db0_re", 32'(mem_re), 32'(t.rd));
          check("db0_we", 32'(mem_we), 32'd0);
          check("db0_bip", 32'(break_in_prog), 32'd1);
          check("db0_hold", 32'(cpu_hold), 32'd1);
          @(negedge clk);
          check("db1_state", 32'(state), 32'(ST_DB1));
          check("db1_we", 32'(mem_we), 32'(!t.rd));
          check("db1_re", 32'(mem_re), 32'd0);
          if (!t.rd) check("db1_wdata", 32'(mem_wdata), 32'(t.data));
          @(negedge clk);
          check("db2_state", 32'(state), 32'(ST_DB2));
          check("db2_strobes", 32'({mem_re, mem_we}), 32'd0);
          @(negedge clk);
          check("end_state", 32'(state), 32'(ST_IDLE));
          check("end_bip", 32'(break_in_prog), 32'd0);
          check("end_dmaDIN", 32'(dmaDIN), 32'(t.din));
          check("end_count", 32'(break_count), 32'(t.cnt));
          n_done++;
        end
      end
    end
  end

  // Requester: raise a break, optionally hold off the boundary, drop on DB1.
  task automatic do_break(input logic [14:0] a, input logic rd, input logic [11:0] d,
                          input bit rnd, input int hold, input bit clr_db2);
    exp_t t;
    bit   seen;
    if (rd) model_din = ref_read(a);
    else ref_mem[a] = d;
    model_count = clr_db2 ? 12'd0 : model_count + 12'd1;
    if (clr_db2) model_late = 1'b0;
    t = '{a, rd, d, model_din, model_count};
    sbq.push_back(t);
    dmaAddr = a; to_disk = rd; dmaDOUT = d; data_break = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      cpu_boundary = 1'b0;
      @(posedge clk); #1;
      check("gate_idle", 32'(state), 32'(ST_IDLE));
      if (i >= int'(MAXW)) model_late = 1'b1;
      check("late_wait", 32'(late), 32'(model_late));
    end
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      cpu_boundary = rnd ? (n >= 5 || $urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
      if (!rnd && n == 0) check("grant_latency", 32'(state), 32'(ST_DB0));
      if (state == ST_DB1) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got no DB1 expected DB1 within 60 cycles");
    end
    data_break = 1'b0;
    dmaAddr = 15'($urandom); to_disk = 1'($urandom); dmaDOUT = 12'($urandom);
    cpu_boundary = 1'($urandom);
    @(posedge clk); #1;
    if (clr_db2) clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; clear = 1'b0; data_break = 1'b0; to_disk = 1'b0;
    cpu_boundary = 1'b0; dmaAddr = '0; dmaDOUT = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_outs", 32'({break_in_prog, cpu_hold, mem_re, mem_we, late}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_dmaDIN", 32'(dmaDIN), 32'd0);
    check("rst_count", 32'(break_count), 32'd0);

    do_break(15'o12345, 1'b0, 12'o7070, 1'b0, 0, 1'b0);
    do_break(15'o00200, 1'b1, 12'o0000, 1'b0, 0, 1'b0);
    do_break(15'o04444, 1'b0, 12'o1357, 1'b0, 0, 1'b0);
    do_break(15'o12345, 1'b1, 12'o0000, 1'b0, 7, 1'b0);
    check("gate_no_late", 32'(late), 32'(model_late));

    do_break(15'o07000, 1'b0, 12'o0123, 1'b0, int'(MAXW), 1'b0);
    check("late_sticky", 32'(late), 32'(model_late));
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    model_late = 1'b0; model_count = '0;
    check("clear_late", 32'(late), 32'(model_late));
    check("clear_count", 32'(break_count), 32'(model_count));

    do_break(15'o00200, 1'b1, 12'o0000, 1'b1, 0, 1'b0);
    do_break(15'o03210, 1'b0, 12'o6543, 1'b0, 0, 1'b1);

    repeat (2) @(posedge clk);
    #1 mon_en = 1'b0;
    dmaAddr = 15'o00777; to_disk = 1'b0; dmaDOUT = 12'o1234;
    data_break = 1'b1; cpu_boundary = 1'b1;
    for (int n = 0; n < 10 && state != ST_DB1; n++) begin
      @(posedge clk); #1;
    end
    check("abort_in_db1", 32'(state), 32'(ST_DB1));
    data_break = 1'b0; reset = 1'b1;
    #1 check("abort_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    model_din = '0; model_count = '0; model_late = 1'b0;
    check("abort_state", 32'(state), 32'(ST_IDLE));
    check("abort_outs", 32'({break_in_prog, cpu_hold, mem_re, mem_we, late}), 32'd0);
    check("abort_count", 32'(break_count), 32'(model_count));
    check("abort_mem", 32'(tb_wr[15'o00777]), 32'd0);
    mon_en = 1'b1;

    base = n_done;
    for (int k = 0; k < 100; k++) begin
      do_break(15'($urandom), 1'($urandom), 12'($urandom), 1'b1, 0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    repeat (2) @(negedge clk);
    check("grants_100", 32'(n_done - base), 32'd100);
    check("count_100", 32'(break_count), 32'd100);
    check("rand_late", 32'(late), 32'(model_late));
    check("sb_empty", 32'(sbq.size()), 32'd0);

    @(posedge clk); #1 mon_en = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    to_disk = 1'b1; data_break = 1'b1; cpu_boundary = 1'b1;
    repeat (4 * 4095) @(posedge clk);
    #1 data_break = 1'b0;
    check("wrap_pre_state", 32'(state), 32'(ST_IDLE));
    check("wrap_4095", 32'(break_count), 32'd4095);
    data_break = 1'b1;
    @(posedge clk); #1 data_break = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("wrap_zero", 32'(break_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
